// File: rtl/hazard_detection_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_detection_unit_pkg
// Shared pipeline definitions used by the hazard detection unit and the debug
// unit: the control-state encoding, the default drain depth and a helper that
// sizes the drain counter.
// ----------------------------------------------------------------------------
package hazard_detection_unit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_DRAIN  = 2'd1;
    localparam state_t ST_HALTED = 2'd2;

    // Stages a halt must still pass through after leaving ID: EX, MEM, WB.
    localparam int N_DRAIN_DEFAULT = 3;

    // Width of a counter that runs 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : hazard_detection_unit_pkg

// File: rtl/hazard_detection_unit.sv
// ----------------------------------------------------------------------------
// hazard_detection_unit
// Pipeline control for a 5-stage in-order core: load-use stalls, branch/jump
// flushes, and the halt sequence (halt drains EX/MEM/WB, then the core parks
// in HALTED until a restart request).
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable              global enable from the debug unit; 0 freezes all
//   i_rs_ifid, i_rt_ifid  source registers of the instruction in ID
//   i_rt_idex             destination rt of the instruction in EX
//   i_mem_read_idex       instruction in EX is a load
//   i_branch_taken_id     branch resolved taken in ID
//   i_jump_id             jump decoded in ID
//   i_halt_id             halt decoded in ID
//   i_restart             leave HALTED and start a new program
//   o_pc_write            PC load enable
//   o_ifid_write          IF/ID latch enable
//   o_ifid_flush          zero IF/ID on the next edge
//   o_idex_bubble         zero ID/EX control bits on the next edge
//   o_pipe_en             enable for ID/EX, EX/MEM, MEM/WB and RF write
//   o_halted              program finished and pipeline drained
//   o_stall_count         saturating count of load-use stalls
// ----------------------------------------------------------------------------
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int N_BITS_REG = 5,
    parameter int N_DRAIN    = N_DRAIN_DEFAULT,
    parameter int N_BITS_CNT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [N_BITS_REG-1:0] i_rs_ifid,
    input  logic [N_BITS_REG-1:0] i_rt_ifid,
    input  logic [N_BITS_REG-1:0] i_rt_idex,
    input  logic                  i_mem_read_idex,
    input  logic                  i_branch_taken_id,
    input  logic                  i_jump_id,
    input  logic                  i_halt_id,
    input  logic                  i_restart,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_ifid_flush,
    output logic                  o_idex_bubble,
    output logic                  o_pipe_en,
    output logic                  o_halted,
    output logic [N_BITS_CNT-1:0] o_stall_count
);

    localparam int                  W_DRAIN    = cnt_width(N_DRAIN);
    localparam logic [W_DRAIN-1:0]  DRAIN_LAST = W_DRAIN'(N_DRAIN - 1);
    localparam logic [N_BITS_CNT-1:0] CNT_MAX  = {N_BITS_CNT{1'b1}};

    state_t                r_state;
    logic [W_DRAIN-1:0]    r_drain_cnt;
    logic [N_BITS_CNT-1:0] r_stall_cnt;

    state_t                w_state_nxt;
    logic [W_DRAIN-1:0]    w_drain_nxt;
    logic [N_BITS_CNT-1:0] w_stall_nxt;
    logic                  w_load_use;

    // Register 0 is hard-wired to zero, so a load targeting it never creates
    // a real dependency. Once the stalled load moves on, EX holds the bubble
    // (mem_read=0), so each load stalls its consumer exactly one cycle.
    assign w_load_use = i_mem_read_idex
                      & (i_rt_idex != '0)
                      & ((i_rt_idex == i_rs_ifid) | (i_rt_idex == i_rt_ifid));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the if/case tree leaves one unassigned and infers a latch.
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_stall_nxt   = r_stall_cnt;
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_en     = 1'b0;

        // While reset is held the state already reads RUN, so the enables are
        // gated explicitly to keep the pipeline frozen until reset releases.
        if (i_rst_n && i_enable) begin
            case (r_state)
                ST_RUN: begin
                    o_pipe_en = 1'b1;
                    if (w_load_use) begin
                        o_idex_bubble = 1'b1;
                        if (r_stall_cnt != CNT_MAX) begin
                            w_stall_nxt = r_stall_cnt + N_BITS_CNT'(1);
                        end
                    end else if (i_branch_taken_id || i_jump_id) begin
                        o_pc_write   = 1'b1;
                        o_ifid_write = 1'b1;
                        o_ifid_flush = 1'b1;
                    end else if (i_halt_id) begin
                        // PC and IF/ID freeze; the halt itself moves into EX.
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        o_pc_write   = 1'b1;
                        o_ifid_write = 1'b1;
                    end
                end

                ST_DRAIN: begin
                    o_idex_bubble = 1'b1;
                    o_pipe_en     = 1'b1;
                    if (r_drain_cnt == DRAIN_LAST) begin
                        w_state_nxt = ST_HALTED;
                        w_drain_nxt = '0;
                    end else begin
                        w_drain_nxt = r_drain_cnt + W_DRAIN'(1);
                    end
                end

                ST_HALTED: begin
                    if (i_restart) begin
                        w_state_nxt = ST_RUN;
                        w_drain_nxt = '0;
                        w_stall_nxt = '0;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to RUN with the pipe frozen.
                    w_state_nxt = ST_RUN;
                    w_drain_nxt = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_stall_cnt <= w_stall_nxt;
        end
    end

    assign o_halted      = (r_state == ST_HALTED);
    assign o_stall_count = r_stall_cnt;

endmodule : hazard_detection_unit

// File: tb/tb_hazard_detection_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Self-checking bench: a vector table for single-cycle RUN behaviour, hand
// sequences for halt/drain/restart, enable freeze, reset and saturation, then
// randomized stimulus against a behavioural model.
// Control word layout: {pc_write, ifid_write, ifid_flush, idex_bubble,
// pipe_en, halted}.
// ----------------------------------------------------------------------------
module tb_hazard_detection_unit;

    localparam int N_BITS_REG = 5;
    localparam int N_DRAIN    = 3;
    localparam int N_BITS_CNT = 4;
    localparam int CNT_SAT    = (1 << N_BITS_CNT) - 1;

    localparam logic [5:0] CTL_NORMAL = 6'b110010;
    localparam logic [5:0] CTL_STALL  = 6'b000110;
    localparam logic [5:0] CTL_FLUSH  = 6'b111010;
    localparam logic [5:0] CTL_HALTID = 6'b000010;
    localparam logic [5:0] CTL_DRAIN  = 6'b000110;
    localparam logic [5:0] CTL_HALTED = 6'b000001;
    localparam logic [5:0] CTL_OFF    = 6'b000000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [N_BITS_REG-1:0] rs_ifid, rt_ifid, rt_idex;
    logic                  mem_read_idex, branch_taken, jump, halt, restart;
    logic                  pc_write, ifid_write, ifid_flush, idex_bubble;
    logic                  pipe_en, halted;
    logic [N_BITS_CNT-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: remaining drain cycles, halted flag, stall total.
    int m_drain_left;
    bit m_halted;
    int m_stall;

    always #5 clk = ~clk;

    hazard_detection_unit #(
        .N_BITS_REG (N_BITS_REG),
        .N_DRAIN    (N_DRAIN),
        .N_BITS_CNT (N_BITS_CNT)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_enable          (enable),
        .i_rs_ifid         (rs_ifid),
        .i_rt_ifid         (rt_ifid),
        .i_rt_idex         (rt_idex),
        .i_mem_read_idex   (mem_read_idex),
        .i_branch_taken_id (branch_taken),
        .i_jump_id         (jump),
        .i_halt_id         (halt),
        .i_restart         (restart),
        .o_pc_write        (pc_write),
        .o_ifid_write      (ifid_write),
        .o_ifid_flush      (ifid_flush),
        .o_idex_bubble     (idex_bubble),
        .o_pipe_en         (pipe_en),
        .o_halted          (halted),
        .o_stall_count     (stall_count)
    );

    typedef struct {
        logic       en;
        logic [4:0] rs, rt, rt_ex;
        logic       mem, br, jmp, hlt, rst_req;
        logic [5:0] exp_ctl;
        logic [3:0] exp_cnt;
    } vec_t;

    task automatic set_in(input logic en, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rt_ex, input logic mem, input logic br,
                          input logic jmp, input logic hlt, input logic rst_req);
        enable        = en;
        rs_ifid       = rs;
        rt_ifid       = rt;
        rt_idex       = rt_ex;
        mem_read_idex = mem;
        branch_taken  = br;
        jump          = jmp;
        halt          = hlt;
        restart       = rst_req;
        #1;
    endtask

    task automatic set_normal();
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_load_use();
        set_in(1'b1, 5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_halt();
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_restart(input logic en);
        set_in(en, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input logic [5:0] exp_ctl,
                         input logic [3:0] exp_cnt);
        logic [5:0] act_ctl;
        act_ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en, halted};
        n_checks++;
        if (act_ctl !== exp_ctl || stall_count !== exp_cnt) begin
            n_errors++;
            $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                     name, act_ctl, stall_count, exp_ctl, exp_cnt);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for the current inputs, then advance the model.
    task automatic model_step(output logic [5:0] c, output logic [3:0] n);
        bit lu;
        n = 4'(m_stall);
        if (!enable) begin
            c = {5'b0, m_halted};
        end else if (m_halted) begin
            c = CTL_HALTED;
            if (restart) begin
                m_halted = 1'b0;
                m_stall  = 0;
            end
        end else if (m_drain_left > 0) begin
            c = CTL_DRAIN;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else begin
            lu = mem_read_idex && (rt_idex != 0)
                 && (rt_idex == rs_ifid || rt_idex == rt_ifid);
            if (lu) begin
                c = CTL_STALL;
                if (m_stall < CNT_SAT) m_stall++;
            end else if (branch_taken || jump) begin
                c = CTL_FLUSH;
            end else if (halt) begin
                c = CTL_HALTID;
                m_drain_left = N_DRAIN;
            end else begin
                c = CTL_NORMAL;
            end
        end
    endtask

    initial begin
        vec_t       vecs[10];
        logic [5:0] ec;
        logic [3:0] en_cnt;

        // {en, rs, rt, rt_ex, mem, br, jmp, hlt, restart, exp_ctl, exp_cnt}
        vecs[0] = '{1, 1, 2, 3, 0, 0, 0, 0, 0, CTL_NORMAL, 0};
        vecs[1] = '{1, 8, 2, 8, 1, 0, 0, 0, 0, CTL_STALL,  0};
        vecs[2] = '{1, 8, 2, 0, 0, 0, 0, 0, 0, CTL_NORMAL, 1};
        vecs[3] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, CTL_NORMAL, 1};
        vecs[4] = '{1, 3, 5, 5, 1, 1, 0, 0, 0, CTL_STALL,  1};
        vecs[5] = '{1, 3, 5, 0, 0, 1, 0, 0, 0, CTL_FLUSH,  2};
        vecs[6] = '{1, 3, 5, 0, 0, 0, 1, 1, 0, CTL_FLUSH,  2};
        vecs[7] = '{1, 7, 7, 7, 0, 0, 0, 0, 1, CTL_NORMAL, 2};
        vecs[8] = '{0, 8, 8, 8, 1, 1, 0, 1, 0, CTL_OFF,    2};
        vecs[9] = '{1, 1, 2, 3, 0, 0, 0, 0, 0, CTL_NORMAL, 2};

        // Reset with live, active inputs: everything must read zero.
        rst_n = 1'b0;
        set_normal();
        check("reset_outputs", CTL_OFF, 0);
        cycle();
        check("reset_held_edge", CTL_OFF, 0);
        rst_n = 1'b1;
        #1;

        // Single-cycle RUN behaviour.
        foreach (vecs[i]) begin
            set_in(vecs[i].en, vecs[i].rs, vecs[i].rt, vecs[i].rt_ex, vecs[i].mem,
                   vecs[i].br, vecs[i].jmp, vecs[i].hlt, vecs[i].rst_req);
            check($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_cnt);
            cycle();
        end

        // Halt, three drain cycles ignoring other requests, halted, restart.
        set_halt();
        check("halt_in_run", CTL_HALTID, 2);
        cycle();
        set_in(1'b1, 5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("drain1_ignores_lu_br", CTL_DRAIN, 2);
        cycle();
        set_restart(1'b1);
        check("drain2_ignores_restart", CTL_DRAIN, 2);
        cycle();
        set_halt();
        check("drain3", CTL_DRAIN, 2);
        cycle();
        set_normal();
        check("halted", CTL_HALTED, 2);
        cycle();
        set_restart(1'b0);
        check("halted_restart_disabled", CTL_HALTED, 2);
        cycle();
        set_restart(1'b1);
        check("halted_restart", CTL_HALTED, 2);
        cycle();
        set_normal();
        check("run_after_restart", CTL_NORMAL, 0);
        cycle();

        // Enable dropped for five cycles mid-drain delays halting by five.
        set_halt();
        check("halt2", CTL_HALTID, 0);
        cycle();
        set_normal();
        check("halt2_drain1", CTL_DRAIN, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("drain_frozen%0d", i), CTL_OFF, 0);
            cycle();
        end
        set_normal();
        check("halt2_drain2", CTL_DRAIN, 0);
        cycle();
        check("halt2_drain3", CTL_DRAIN, 0);
        cycle();
        check("halt2_halted", CTL_HALTED, 0);
        set_restart(1'b1);
        cycle();

        // Reset asserted in the middle of a drain.
        set_load_use();
        check("pre_reset_stall", CTL_STALL, 0);
        cycle();
        set_halt();
        check("halt3", CTL_HALTID, 1);
        cycle();
        set_normal();
        check("halt3_drain1", CTL_DRAIN, 1);
        set_load_use();
        rst_n = 1'b0;
        #1;
        check("reset_mid_drain", CTL_OFF, 0);
        cycle();
        check("reset_mid_drain_edge", CTL_OFF, 0);
        #2;
        rst_n = 1'b1;
        set_normal();
        check("after_reset_run", CTL_NORMAL, 0);
        cycle();
        check("after_reset_run_edge", CTL_NORMAL, 0);
        cycle();

        // Stall counter saturation.
        for (int i = 0; i < 18; i++) begin
            set_load_use();
            check($sformatf("sat_stall%0d", i), CTL_STALL,
                  4'((i < CNT_SAT) ? i : CNT_SAT));
            cycle();
        end
        set_normal();
        check("sat_hold", CTL_NORMAL, 4'hF);
        cycle();

        // Randomized run against the behavioural model.
        m_drain_left = 0;
        m_halted     = 1'b0;
        m_stall      = CNT_SAT;
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) != 0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            model_step(ec, en_cnt);
            check($sformatf("rand%0d", i), ec, en_cnt);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_detection_unit

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter N_BITS_REG, default 5, register-address width.
REQ-002 SHALL have parameter N_DRAIN, default 3, drain cycles after halt leaves ID (EX, MEM, WB).
REQ-003 SHALL have parameter N_BITS_CNT, default 16, stall-counter width.
REQ-004 SHALL have ports as listed: one clock; reset is asynchronous and active-low; clock and reset named i_clk, i_rst_n.
  i_clk  in  1  clock
  i_rst_n  in  1  async active-low reset
  i_enable  in  1  debug-unit global enable; 0 freezes everything
  i_rs_ifid  in  N_BITS_REG  rs of instruction in ID
  i_rt_ifid  in  N_BITS_REG  rt of instruction in ID
  i_rt_idex  in  N_BITS_REG  destination rt of instruction in EX
  i_mem_read_idex  in  1  instruction in EX is a load
  i_branch_taken_id  in  1  branch resolved taken in ID
  i_jump_id  in  1  jump decoded in ID
  i_halt_id  in  1  halt decoded in ID
  i_restart  in  1  leave HALTED, start new program
  o_pc_write  out  1  PC load enable
  o_ifid_write  out  1  IF/ID latch enable
  o_ifid_flush  out  1  zero IF/ID on next edge
  o_idex_bubble  out  1  zero ID/EX control bits on next edge
  o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB latches and register-file write
  o_halted  out  1  program finished, pipeline drained
  o_stall_count  out  N_BITS_CNT  saturating load-use stall counter

Function
REQ-005 SHALL hold a state register: RUN, DRAIN, HALTED; plus drain counter (clog2(N_DRAIN) bits) and stall counter.
REQ-006 SHALL compute load_use = i_mem_read_idex & (i_rt_idex != 0) & (i_rt_idex == i_rs_ifid | i_rt_idex == i_rt_ifid), combinationally.
REQ-007 SHALL, when i_enable=0, drive o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=0, o_pipe_en=0, and hold state and both counters; o_halted reflects state.
REQ-008 SHALL, in RUN with i_enable=1, apply priority load_use > branch/jump > halt > normal.
REQ-009 SHALL on load_use: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=0, o_pipe_en=1; stall counter +1 (saturate at all-ones); stay RUN; exactly one stall cycle per load since the load leaves EX.
REQ-010 SHALL on i_branch_taken_id|i_jump_id (no load_use): o_pc_write=1, o_ifid_write=1, o_ifid_flush=1, o_idex_bubble=0; i_halt_id ignored this cycle.
REQ-011 SHALL on i_halt_id (no load_use, no branch/jump): o_pc_write=0, o_ifid_write=0, o_idex_bubble=0 (halt enters EX), o_pipe_en=1; next state DRAIN, drain counter 0.
REQ-012 SHALL otherwise in RUN: o_pc_write=1, o_ifid_write=1, o_ifid_flush=0, o_idex_bubble=0, o_pipe_en=1.
REQ-013 SHALL in DRAIN (i_enable=1): o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_pipe_en=1; counter +1 per cycle; at counter==N_DRAIN-1 next state HALTED; load_use/branch/halt/i_restart ignored.
REQ-014 SHALL in HALTED: o_halted=1, o_pipe_en=0, all write/flush/bubble outputs 0; on i_restart=1 with i_enable=1 next state RUN, stall counter cleared, drain counter 0.
REQ-015 SHALL ignore i_restart in RUN and DRAIN.
REQ-016 SHALL make o_halted a decode of the registered state only (no input path).

Reset
REQ-017 SHALL, while i_rst_n=0, force state RUN, drain counter 0, stall counter 0, and all outputs 0 (including o_pc_write, o_pipe_en) irrespective of inputs.
REQ-018 SHALL, on reset assertion mid-DRAIN or in HALTED, return to RUN immediately; first enabled edge after deassertion is normal RUN behaviour.

Structure
REQ-019 SHALL take state encoding (2-bit localparams ST_RUN, ST_DRAIN, ST_HALTED) and N_DRAIN default from the shared pipeline package, also used by the debug unit.
REQ-020 SHALL be a single module with no sub-modules; next-state/output logic in one combinational block, registers in one async-reset sequential block.

Verification
REQ-021 SHALL cover load-use: mem_read_idex=1, rt_idex=8, rs_ifid=8 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, stall_count 0->1.
REQ-022 SHALL cover rt_idex=0 with rs_ifid=0, mem_read_idex=1 -> no stall, pc_write=1, stall_count unchanged.
REQ-023 SHALL cover load_use and branch_taken same cycle -> stall only, ifid_flush=0; next cycle branch alone -> ifid_flush=1.
REQ-024 SHALL cover halt_id in RUN -> DRAIN 3 cycles with idex_bubble=1, o_halted=1 on 4th cycle, pipe_en=0; i_restart -> RUN, stall_count=0.
REQ-025 SHALL cover i_enable=0 during DRAIN for 5 cycles -> counter frozen, halting delayed by 5 cycles; reset asserted mid-DRAIN -> state RUN, all outputs 0 during reset.
REQ-026 SHALL cover stall counter forced near saturation (N_BITS_CNT=4, 16 load-use stalls) -> o_stall_count holds 4'hF.
